// File: rtl/mantissa_divider_if.sv
// Handshake/data bundle for mantissa_divider.
//   start            request (level, sampled only while the divider is idle)
//   x, y             dividend / divisor mantissas (W bits, hidden bit included)
//   q, rem           registered quotient (W+1 bits) and remainder (W bits)
//   div_zero, ovf    status of the last completed op
//   busy, out_en     engine active / one-cycle result-valid pulse
interface mantissa_divider_if #(parameter int W = 24);
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W:0]   q;
    logic [W-1:0] rem;
    logic         div_zero;
    logic         ovf;
    logic         busy;
    logic         out_en;

    modport master (output start, x, y,
                    input  q, rem, div_zero, ovf, busy, out_en);
    modport slave  (input  start, x, y,
                    output q, rem, div_zero, ovf, busy, out_en);
endinterface

// File: rtl/mantissa_divider.sv
// Sequential restoring divider for FP mantissas.
// Computes q = floor(x * 2^W / y) and rem = x * 2^W - q * y, one quotient bit
// per clock (W+1 iterations). y == 0 and x >= 2y are resolved in one cycle with
// a saturated quotient and the matching flag.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    mantissa_divider_if.slave (start/x/y in; q/rem/flags/busy/out_en out)
module mantissa_divider #(
    parameter int W = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    mantissa_divider_if.slave    bus
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    logic [W:0]    r_q;      // partial remainder, always < 2*y
    logic [W-1:0]  y_q;      // latched divisor
    logic [W-1:0]  qsh;      // quotient bits produced so far (shifted in at LSB)
    logic [CW-1:0] cnt;      // iteration index k, W down to 0

    logic [W:0]    q_r;
    logic [W-1:0]  rem_r;
    logic          dz_r;
    logic          ovf_r;
    logic          busy_r;
    logic          out_en_r;

    logic [W:0]    diff;
    logic          qbit;
    logic [W:0]    r_sel;
    logic [W:0]    qsh_nxt;

    // One restoring step: subtract if it fits, keep R otherwise.
    always_comb begin
        diff    = r_q - {1'b0, y_q};
        qbit    = (r_q >= {1'b0, y_q});
        r_sel   = qbit ? diff : r_q;
        qsh_nxt = {qsh, qbit};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            r_q      <= '0;
            y_q      <= '0;
            qsh      <= '0;
            cnt      <= '0;
            q_r      <= '0;
            rem_r    <= '0;
            dz_r     <= 1'b0;
            ovf_r    <= 1'b0;
            busy_r   <= 1'b0;
            out_en_r <= 1'b0;
        end else begin
            out_en_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        y_q    <= bus.y;
                        busy_r <= 1'b1;
                        if (bus.y == '0) begin
                            state    <= DONE;
                            q_r      <= '1;
                            rem_r    <= '0;
                            dz_r     <= 1'b1;
                            ovf_r    <= 1'b0;
                            out_en_r <= 1'b1;
                        end else if ({1'b0, bus.x} >= {bus.y, 1'b0}) begin
                            // quotient would need W+2 bits
                            state    <= DONE;
                            q_r      <= '1;
                            rem_r    <= '0;
                            dz_r     <= 1'b0;
                            ovf_r    <= 1'b1;
                            out_en_r <= 1'b1;
                        end else begin
                            state <= CALC;
                            r_q   <= {1'b0, bus.x};
                            qsh   <= '0;
                            cnt   <= CW'(W);
                        end
                    end
                end
                CALC: begin
                    qsh <= qsh_nxt[W-1:0];
                    // R < y after the step, so the shift cannot lose bit W
                    r_q <= r_sel << 1;
                    if (cnt == '0) begin
                        q_r      <= qsh_nxt;
                        rem_r    <= r_sel[W-1:0];
                        dz_r     <= 1'b0;
                        ovf_r    <= 1'b0;
                        out_en_r <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q        = q_r;
    assign bus.rem      = rem_r;
    assign bus.div_zero = dz_r;
    assign bus.ovf      = ovf_r;
    assign bus.busy     = busy_r;
    assign bus.out_en   = out_en_r;
endmodule

// File: tb/tb_mantissa_divider.sv
// Self-checking bench for mantissa_divider: directed corner cases, reset
// abort, held-start throughput and randomized ops against a division model.
module tb_mantissa_divider;
    localparam int W = 24;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   cyc;

    mantissa_divider_if #(.W(W)) bus ();

    mantissa_divider #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division of x * 2^W by y, plus the two early-outs.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W:0] eq, output logic [W-1:0] er,
                         output logic ez, output logic eo, output int lat);
        longint unsigned num, den;
        num = longint'(a) << W;
        den = longint'(b);
        ez = 1'b0; eo = 1'b0;
        if (b == 0) begin
            eq = '1; er = '0; ez = 1'b1; lat = 0;
        end else if (longint'(a) >= 2 * den) begin
            eq = '1; er = '0; eo = 1'b1; lat = 0;
        end else begin
            eq  = (W+1)'(num / den);
            er  = W'(num % den);
            lat = W + 1;
        end
    endtask

    // Wait (bounded) for out_en, sampling on negedges; returns edges waited.
    task automatic wait_pulse(input int bound, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n <= bound) begin
            @(negedge clk);
            if (bus.out_en) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        if (!ok) chk("timeout_out_en", 64'd0, 64'd1);
    endtask

    // One op: start for a single edge, check latency, result and pulse width.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit full);
        logic [W:0]   eq;
        logic [W-1:0] er;
        logic         ez, eo;
        int           lat, n;
        bit           ok;
        model(a, b, eq, er, ez, eo, lat);
        @(negedge clk);
        bus.start = 1'b1; bus.x = a; bus.y = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.x = $urandom; bus.y = $urandom;   // must have no effect after E0
        wait_pulse(40, n, ok);
        if (ok) begin
            chk({tag, "_q"}, 64'(bus.q), 64'(eq));
            chk({tag, "_rem"}, 64'(bus.rem), 64'(er));
            if (full) begin
                chk({tag, "_lat"}, 64'(n), 64'(lat));
                chk({tag, "_dz"}, 64'(bus.div_zero), 64'(ez));
                chk({tag, "_ovf"}, 64'(bus.ovf), 64'(eo));
                chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
            end else if (!ez && !eo) begin
                // identity check independent of the model's quotient
                chk({tag, "_ident"}, 64'(longint'(bus.q) * longint'(b) + longint'(bus.rem)),
                    64'(longint'(a) << W));
                chk({tag, "_remlt"}, 64'(bus.rem < b), 64'd1);
            end
            @(negedge clk);
            if (full) begin
                chk({tag, "_pulse1"}, 64'(bus.out_en), 64'd0);
                chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
            end
        end
    endtask

    initial begin
        int          n, c1, c2;
        bit          ok, seen;
        logic [W-1:0] a, b;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        bus.start = 1'b0; bus.x = '0; bus.y = '0;
        #1;
        chk("rst_q", 64'(bus.q), 64'd0);
        chk("rst_rem", 64'(bus.rem), 64'd0);
        chk("rst_flags", 64'({bus.div_zero, bus.ovf, bus.busy, bus.out_en}), 64'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        do_op("one", 24'h800000, 24'h800000, 1'b1);
        do_op("c_over_8", 24'hC00000, 24'h800000, 1'b1);
        do_op("8_over_c", 24'h800000, 24'hC00000, 1'b1);
        chk("8_over_c_const", 64'(bus.q), 64'h0AAAAAA);
        do_op("yzero", 24'h81FF20, 24'h000000, 1'b1);
        do_op("ovf", 24'hFFFFFF, 24'h000001, 1'b1);
        do_op("ovf_edge", 24'h000002, 24'h000001, 1'b1);
        do_op("no_ovf_edge", 24'hFFFFFF, 24'h800000, 1'b1);
        do_op("max_q", 24'hFFFFFF, 24'h800000, 1'b1);

        // Reset during CALC: outputs clear at once and no pulse ever appears.
        @(negedge clk);
        bus.start = 1'b1; bus.x = 24'hC00000; bus.y = 24'h800000;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_q", 64'(bus.q), 64'd0);
        chk("abort_flags", 64'({bus.div_zero, bus.ovf, bus.busy, bus.out_en}), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_en) seen = 1'b1;
        end
        chk("abort_no_pulse", 64'(seen), 64'd0);
        do_op("after_abort", 24'h800000, 24'h800000, 1'b1);

        // Held start: operands latched at E0, pulses W+3 apart, q holds meanwhile.
        @(negedge clk);
        bus.start = 1'b1; bus.x = 24'hC00000; bus.y = 24'h800000;
        repeat (6) @(negedge clk);
        chk("hold_q_old", 64'(bus.q), 64'h1000000);
        bus.x = 24'h800000; bus.y = 24'hC00000;
        wait_pulse(40, n, ok);
        c1 = cyc;
        chk("hold_q1", 64'(bus.q), 64'h1800000);
        chk("hold_rem1", 64'(bus.rem), 64'd0);
        @(negedge clk);
        chk("hold_q_keep", 64'(bus.q), 64'h1800000);
        wait_pulse(40, n, ok);
        c2 = cyc;
        bus.start = 1'b0;
        chk("hold_period", 64'(c2 - c1), 64'(W + 3));
        chk("hold_q2", 64'(bus.q), 64'h0AAAAAA);
        chk("hold_rem2", 64'(bus.rem), 64'h800000);

        // Random normalized operands, then a few unrestricted ones.
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom) | 24'h800000;
            b = W'($urandom) | 24'h800000;
            do_op("rnd_norm", a, b, 1'b0);
        end
        for (int i = 0; i < 60; i++) begin
            a = W'($urandom);
            b = (i % 10 == 0) ? '0 : W'($urandom >> $urandom_range(0, 23));
            do_op("rnd_any", a, b, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
